// File: rtl/sp_ram_cfg.sv
// Single-port RAM with byte-lane writes, a configurable read latency and write-port read mode,
// and a self-clearing sequence after reset that rejects requests while it runs.
module sp_ram_cfg #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 3,
  parameter int RD_LAT  = 1,
  parameter int WR_MODE = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic                  wea,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [DATA_W-1:0]     din,
  input  logic [ADDR_W-1:0]     addr,
  output logic [DATA_W-1:0]     dout,
  output logic                  read_valid,
  output logic                  busy,
  output logic                  req_drop
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int NB    = DATA_W/8;

  typedef enum logic {CLEAR, READY} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   cnt, cnt_nxt;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   old_word, merged;
  logic                access;
  logic                s_v, p_v, o_v;
  logic [DATA_W-1:0]   s_d, p_d, o_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (state == CLEAR) begin
      cnt_nxt = cnt + ADDR_W'(1);
      if (cnt == '1) state_nxt = READY;
    end
  end

  assign busy   = (state == CLEAR);
  assign access = ena && (state == READY);

  always_comb begin
    old_word = mem[addr];
    merged   = old_word;
    for (int unsigned i = 0; i < NB; i++)
      if (be[i]) merged[8*i +: 8] = din[8*i +: 8];
  end

  // Stage-0 result: reads and non-NO_CHANGE writes produce a word for dout.
  assign s_v = access && (!wea || (WR_MODE != 2));
  assign s_d = (wea && (WR_MODE == 1)) ? merged : old_word;

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR)
        mem[cnt] <= '0;
      else if (access && wea)
        mem[addr] <= merged;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) req_drop <= 1'b0;
    else     req_drop <= ena && busy;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_v <= 1'b0;
      p_d <= '0;
    end else begin
      p_v <= s_v;
      p_d <= s_d;
    end
  end

  assign o_v = (RD_LAT == 2) ? p_v : s_v;
  assign o_d = (RD_LAT == 2) ? p_d : s_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      dout       <= '0;
      read_valid <= 1'b0;
    end else begin
      read_valid <= o_v;
      if (o_v) dout <= o_d;
    end
  end

endmodule
